regfile_wb_scoreboard: RTL and testbench
========================================

// Module: regfile_wb_scoreboard
// PURPOSE
//  Sequences the 32x32 register file in the pipelined RISC CPU. A 32-bit scoreboard tracks
//  registers with an outstanding write and stalls the DOF stage on RAW/WAW hazards. A
//  round-robin arbiter shares the single register-file write port between two writeback
//  requesters: wb0 (single-cycle ALU) and wb1 (multi-cycle mul/load). Same-cycle WB->DOF
//  forward indications are generated so that a stall is not needed while the register is being written.
// PARAMETERS
//  NREG    32  number of architectural registers (R0 hardwired zero, never pending)
//  AW      5   register address width, log2(NREG)
//  DW      32  data width
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  iss_valid    in   1   DOF stage presents an instruction for issue
//  iss_dest     in   AW  destination register of issuing instruction (0 = no write)
//  iss_src_a    in   AW  source A address (AA)
//  iss_use_a    in   1   instruction reads source A
//  iss_src_b    in   AW  source B address (BA)
//  iss_use_b    in   1   instruction reads source B
//  iss_stall    out  1   hold DOF; instruction not issued this cycle
//  wbN_valid    in   1   writeback request, N=0,1 (addr/data held stable until ready)
//  wbN_addr     in   AW  writeback destination register
//  wbN_data     in   DW  writeback data
//  wbN_ready    out  1   request N granted this cycle (transfer = valid & ready)
//  rf_d_addr    out  AW  register file D_addr
//  rf_d_data    out  DW  register file D_data
//  rf_d_write   out  1   register file D_write
//  fwd_a_hit    out  1   source A is being written this cycle; use fwd_data for A
//  fwd_b_hit    out  1   source B is being written this cycle; use fwd_data for B
//  fwd_data     out  DW  data on the write port this cycle (= rf_d_data)
//  pending_cnt  out  6   registered count of set scoreboard bits (0..31)
//  err_wb       out  1   sticky: writeback granted to a nonzero register with no pending bit
// BEHAVIOUR
//  - Reset (rst_n low, async): pending[31:0]=0, rr_ptr=0, pending_cnt=0, err_wb=0. While
//    rst_n low, combinational outputs are forced: iss_stall=1, wb0/1_ready=0, rf_d_write=0,
//    fwd_*_hit=0. Reset mid-request simply drops the request; requesters re-present it.
//  - Arbitration (combinational grant, zero latency): only one valid -> grant it. Both valid ->
//    grant wb0 if rr_ptr=0, else wb1; on that cycle rr_ptr <= index of the non-granted
//    requester. rr_ptr is unchanged when at most one requester is valid.
//  - Write port: wg = any grant; rf_d_addr/data = granted addr/data (wb0's when idle);
//    rf_d_write = wg & (addr!=0). Grant to R0 is consumed, no write.
//  - Hazard terms (w = wg & waddr!=0): clr(r) = w & waddr==r.
//    hazA = use_a & src_a!=0 & pending[src_a] & ~clr(src_a); hazB likewise;
//    waw = dest!=0 & pending[dest] & ~clr(dest). iss_stall = iss_valid & (hazA|hazB|waw).
//  - fwd_a_hit = iss_use_a & clr(src_a); fwd_b_hit likewise (independent of iss_valid).
//  - Issue accept = iss_valid & ~iss_stall; sets pending[dest] at next edge if dest!=0.
//  - Scoreboard update: pending <= (pending & ~clrmask) | setmask; if same register is
//    cleared and set in one cycle, set wins (bit stays 1, count unchanged).
//  - pending_cnt <= pending_cnt + set - clear (each 0/1); never wraps (max 31, R0 excluded).
//  - err_wb set when wg & waddr!=0 & ~pending[waddr]; write still performed; cleared only by reset.
//  - Stall never depends on wb readiness; wbN_ready never depends on iss_* (no comb loops).
// TESTING
//  1 Reset: rst_n=0 mid-cycle with wb0_valid=1 -> ready=0, rf_d_write=0, pending_cnt=0, err_wb=0.
//  2 RAW: issue dest=5; next cycle issue src_a=5 use_a=1 -> iss_stall=1 each cycle until wb1
//    writes R5 (0xDEADBEEF); that cycle stall=0, fwd_a_hit=1, fwd_data=0xDEADBEEF, cnt 1->0.
//  3 Arbitration: wb0/wb1 both valid 4 cycles -> grants wb0,wb1,wb0,wb1; single valid wb1 -> granted, rr unchanged.
//  4 WAW + set-wins: pending R7, issue dest=7 while wb0 writes R7 -> no stall, pending[7]=1, cnt unchanged.
//  5 R0: issue dest=0 src_a=0 -> no stall, cnt 0; wb0 addr=0 -> ready=1, rf_d_write=0, err_wb=0.
//  6 Error: wb1 to R9 with pending[9]=0 -> write performed, err_wb=1 and stays 1 until rst_n=0.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_wb_scoreboard
//   Register-file write-port sequencer for the pipelined RISC CPU.
//   - A scoreboard holds one pending bit per architectural register that has
//     an outstanding write. It stalls the DOF stage on RAW and WAW hazards.
//   - A round-robin arbiter shares the single write port between wb0
//     (single-cycle ALU) and wb1 (multi-cycle mul/load).
//   - Same-cycle forward hits let DOF take the value being written instead
//     of stalling.
//
// Ports
//   clk, rst_n                 clock / async active-low reset
//   iss_valid, iss_dest        DOF issue request and its destination
//   iss_src_a/b, iss_use_a/b   DOF source addresses and their use flags
//   iss_stall                  hold DOF (instruction not issued)
//   wbN_valid/addr/data        writeback requests, N = 0,1
//   wbN_ready                  writeback request N granted this cycle
//   rf_d_addr/data/write       register-file write port
//   fwd_a_hit, fwd_b_hit       source is being written this cycle
//   fwd_data                   data on the write port (same as rf_d_data)
//   pending_cnt                number of pending registers (registered)
//   err_wb                     sticky: write to a register with no pending bit
// ---------------------------------------------------------------------------
module regfile_wb_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_dest,
  input  logic [AW-1:0] iss_src_a,
  input  logic          iss_use_a,
  input  logic [AW-1:0] iss_src_b,
  input  logic          iss_use_b,
  output logic          iss_stall,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic [AW-1:0] rf_d_addr,
  output logic [DW-1:0] rf_d_data,
  output logic          rf_d_write,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_data,
  output logic [5:0]    pending_cnt,
  output logic          err_wb
);

  typedef enum logic {
    RR_WB0 = 1'b0,
    RR_WB1 = 1'b1
  } rr_e;

  rr_e             rr_ptr;
  rr_e             rr_nxt;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic            g0;
  logic            g1;
  logic            wg;
  logic            w;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            clr_a;
  logic            clr_b;
  logic            clr_d;
  logic            haz_a;
  logic            haz_b;
  logic            waw;
  logic            accept;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            err_set;

  // Arbitration and write port. Grants are gated by rst_n so that a request
  // presented during reset is dropped rather than written.
  always_comb begin
    g0     = rst_n & wb0_valid & (~wb1_valid | (rr_ptr == RR_WB0));
    g1     = rst_n & wb1_valid & (~wb0_valid | (rr_ptr == RR_WB1));
    wg     = g0 | g1;
    waddr  = g1 ? wb1_addr : wb0_addr;
    wdata  = g1 ? wb1_data : wb0_data;
    w      = wg & (waddr != '0);
    rr_nxt = rr_ptr;
    if (wb0_valid & wb1_valid)
      rr_nxt = g0 ? RR_WB1 : RR_WB0;
  end

  assign wb0_ready  = g0;
  assign wb1_ready  = g1;
  assign rf_d_addr  = waddr;
  assign rf_d_data  = wdata;
  assign rf_d_write = w;
  assign fwd_data   = wdata;

  // Hazard detection. A register written this cycle no longer blocks DOF:
  // its value is taken from the forward path instead.
  always_comb begin
    clr_a     = w & (waddr == iss_src_a);
    clr_b     = w & (waddr == iss_src_b);
    clr_d     = w & (waddr == iss_dest);
    haz_a     = iss_use_a & (iss_src_a != '0) & pending[iss_src_a] & ~clr_a;
    haz_b     = iss_use_b & (iss_src_b != '0) & pending[iss_src_b] & ~clr_b;
    waw       = (iss_dest != '0) & pending[iss_dest] & ~clr_d;
    iss_stall = ~rst_n | (iss_valid & (haz_a | haz_b | waw));
    fwd_a_hit = iss_use_a & clr_a;
    fwd_b_hit = iss_use_b & clr_b;
    accept    = iss_valid & ~iss_stall;
  end

  // Scoreboard next state. The count moves only on a real 0->1 or 1->0
  // transition, so a same-register clear+set leaves it unchanged and a write
  // to a non-pending register never decrements it.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (w)
      clr_mask = NREG'(1) << waddr;
    if (accept & (iss_dest != '0))
      set_mask = NREG'(1) << iss_dest;
    pending_nxt = ((pending & ~clr_mask) | set_mask) & ~NREG'(1);
    cnt_inc     = |(set_mask & ~pending);
    cnt_dec     = |(clr_mask & pending & ~set_mask);
    err_set     = w & ~pending[waddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      rr_ptr      <= RR_WB0;
      pending_cnt <= '0;
      err_wb      <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      rr_ptr      <= rr_nxt;
      pending_cnt <= pending_cnt + 6'(cnt_inc) - 6'(cnt_dec);
      err_wb      <= err_wb | err_set;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic [4:0]  iss_src_a;
  logic        iss_use_a;
  logic [4:0]  iss_src_b;
  logic        iss_use_b;
  logic        iss_stall;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic [4:0]  rf_d_addr;
  logic [31:0] rf_d_data;
  logic        rf_d_write;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_data;
  logic [5:0]  pending_cnt;
  logic        err_wb;

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .iss_src_a(iss_src_a), .iss_use_a(iss_use_a),
    .iss_src_b(iss_src_b), .iss_use_b(iss_use_b),
    .iss_stall(iss_stall),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_d_addr(rf_d_addr), .rf_d_data(rf_d_data), .rf_d_write(rf_d_write),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data),
    .pending_cnt(pending_cnt), .err_wb(err_wb)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: a set of pending registers, whose turn it is on
  // a tie, and the sticky error flag.
  bit          pend_m [32];
  bit          turn_wb1;
  bit          err_m;
  // Per-cycle model decisions (valid after settle()).
  bit          m_g0, m_g1, m_w, m_stall;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 1; i < 32; i++) c += int'(pend_m[i]);
    return c;
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    return (r != 0) && pend_m[r] && !(m_w && m_wa == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    turn_wb1 = 1'b0;
    err_m    = 1'b0;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_dest = 0; iss_src_a = 0; iss_use_a = 0;
    iss_src_b = 0; iss_use_b = 0;
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
  endtask

  // Evaluate the model for the current inputs and compare every output.
  task automatic settle();
    #1;
    if (wb0_valid && wb1_valid) begin
      m_g0 = !turn_wb1; m_g1 = turn_wb1;
    end else begin
      m_g0 = wb0_valid; m_g1 = wb1_valid;
    end
    m_wa = m_g1 ? wb1_addr : wb0_addr;
    m_wd = m_g1 ? wb1_data : wb0_data;
    m_w  = (m_g0 || m_g1) && m_wa != 0;
    m_stall = iss_valid && ((iss_use_a && blocked(iss_src_a)) ||
                            (iss_use_b && blocked(iss_src_b)) ||
                            blocked(iss_dest));
    chk("stall",   32'(iss_stall),  32'(m_stall));
    chk("ready0",  32'(wb0_ready),  32'(m_g0));
    chk("ready1",  32'(wb1_ready),  32'(m_g1));
    chk("rf_addr", 32'(rf_d_addr),  32'(m_wa));
    chk("rf_data", rf_d_data,       m_wd);
    chk("rf_wr",   32'(rf_d_write), 32'(m_w));
    chk("fwd_a",   32'(fwd_a_hit),  32'(iss_use_a && m_w && m_wa == iss_src_a));
    chk("fwd_b",   32'(fwd_b_hit),  32'(iss_use_b && m_w && m_wa == iss_src_b));
    chk("fwd_data", fwd_data,       m_wd);
    chk("cnt",     32'(pending_cnt), 32'(model_cnt()));
    chk("err",     32'(err_wb),     32'(err_m));
  endtask

  // Clock edge: the model retires the write first, then applies the issue,
  // so a same-register clear and set leaves the register pending.
  task automatic adv();
    @(posedge clk);
    if (m_w) begin
      if (!pend_m[m_wa]) err_m = 1'b1;
      pend_m[m_wa] = 1'b0;
    end
    if (iss_valid && !m_stall && iss_dest != 0) pend_m[iss_dest] = 1'b1;
    if (wb0_valid && wb1_valid) turn_wb1 = m_g0;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  // Reset asserted asynchronously a little after a negedge; outputs are
  // checked while reset is low, then released on a later negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(iss_stall),  32'd1);
    chk("rst_rdy0",  32'(wb0_ready),  32'd0);
    chk("rst_rdy1",  32'(wb1_ready),  32'd0);
    chk("rst_wr",    32'(rf_d_write), 32'd0);
    chk("rst_fwd",   32'({fwd_a_hit, fwd_b_hit}), 32'd0);
    chk("rst_cnt",   32'(pending_cnt), 32'd0);
    chk("rst_err",   32'(err_wb),     32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    int q[$];
    for (int i = 1; i < 32; i++) if (pend_m[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(4, 0) != 0)
      return 5'(q[$urandom_range(q.size() - 1, 0)]);
    return 5'($urandom_range(31, 0));
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset mid-cycle while wb0 is requesting.
    wb0_valid = 1; wb0_addr = 5'd3; wb0_data = 32'h1234_5678;
    do_reset();

    // RAW on R5 resolved by a wb1 write with forwarding.
    iss_valid = 1; iss_dest = 5'd5;
    step();
    iss_dest = 5'd0; iss_src_a = 5'd5; iss_use_a = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("raw_stall", 32'(iss_stall), 32'd1);
      chk("raw_cnt1", 32'(pending_cnt), 32'd1);
      adv();
    end
    wb1_valid = 1; wb1_addr = 5'd5; wb1_data = 32'hDEAD_BEEF;
    settle();
    chk("raw_release", 32'(iss_stall), 32'd0);
    chk("raw_fwd", 32'(fwd_a_hit), 32'd1);
    chk("raw_fdata", fwd_data, 32'hDEAD_BEEF);
    adv();
    idle_inputs();
    settle();
    chk("raw_cnt0", 32'(pending_cnt), 32'd0);
    adv();

    // Round-robin arbitration from a fresh reset (wb0 has priority first).
    do_reset();
    wb0_valid = 1; wb0_addr = 0; wb0_data = 32'h1111;
    wb1_valid = 1; wb1_addr = 0; wb1_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_data", rf_d_data, (i % 2 == 0) ? 32'h1111 : 32'h2222);
      adv();
    end
    wb0_valid = 0;
    settle();
    chk("rr_single", 32'(wb1_ready), 32'd1);
    adv();
    wb0_valid = 1;
    settle();
    chk("rr_kept", 32'(wb0_ready), 32'd1);
    adv();
    idle_inputs();

    // WAW with set-wins on R7.
    iss_valid = 1; iss_dest = 5'd7;
    step();
    wb0_valid = 1; wb0_addr = 5'd7; wb0_data = 32'h77;
    settle();
    chk("waw_nostall", 32'(iss_stall), 32'd0);
    adv();
    idle_inputs();
    settle();
    chk("waw_cnt", 32'(pending_cnt), 32'd1);
    adv();
    wb0_valid = 1; wb0_addr = 5'd7;
    step();
    idle_inputs();

    // R0 is never pending and a write to it is consumed silently.
    iss_valid = 1; iss_dest = 0; iss_src_a = 0; iss_use_a = 1;
    settle();
    chk("r0_stall", 32'(iss_stall), 32'd0);
    adv();
    idle_inputs();
    wb0_valid = 1; wb0_addr = 0; wb0_data = 32'hFFFF_FFFF;
    settle();
    chk("r0_ready", 32'(wb0_ready), 32'd1);
    chk("r0_wr", 32'(rf_d_write), 32'd0);
    adv();
    idle_inputs();
    settle();
    chk("r0_cnt", 32'(pending_cnt), 32'd0);
    chk("r0_err", 32'(err_wb), 32'd0);
    adv();

    // Spurious write to R9 sets the sticky error.
    wb1_valid = 1; wb1_addr = 5'd9; wb1_data = 32'h9999;
    settle();
    chk("err_wr", 32'(rf_d_write), 32'd1);
    adv();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("err_sticky", 32'(err_wb), 32'd1);
      adv();
    end
    do_reset();

    // Randomized traffic; requesters hold addr/data until granted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(599, 0) == 0) begin
        do_reset();
        m_g0 = 0; m_g1 = 0;
        wb0_valid = 0; wb1_valid = 0;
      end
      if (!wb0_valid || m_g0) begin
        wb0_valid = ($urandom_range(2, 0) != 0);
        wb0_addr  = pick_reg();
        wb0_data  = $urandom;
      end
      if (!wb1_valid || m_g1) begin
        wb1_valid = ($urandom_range(2, 0) == 0);
        wb1_addr  = pick_reg();
        wb1_data  = $urandom;
      end
      iss_valid = ($urandom_range(3, 0) != 0);
      iss_dest  = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      iss_src_a = pick_reg();
      iss_use_a = 1'($urandom);
      iss_src_b = pick_reg();
      iss_use_b = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
